// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS core's memory-side responders:
// FSM states, default latency and response error codes.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam int DEFAULT_WAIT_CYCLES = 2;

    localparam logic RESP_ERR_NONE = 1'b0;
    localparam logic RESP_ERR_ADDR = 1'b1;

    // A word access is illegal if it is not word aligned or lies beyond the array.
    function automatic logic addr_fault(input logic [31:0] addr, input int unsigned addr_width);
        return (addr[1:0] != 2'b00) || ((addr >> (addr_width + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word array with one write port, one registered read port and an
// asynchronous clear of both the storage and the read register.
module mem_array #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic                  rd_clr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // rd_en wins over rd_clr; the two are never requested together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end else if (rd_clr) begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-port memory responder: one load/store at a time with WAIT_CYCLES of latency.
// Handshake: a channel transfers on a rising edge where valid && ready; the payload holds until then.
module data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 5,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    input  logic        resp_ready
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mem_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic                  cap_write;
    logic                  cap_err;
    logic [ADDR_WIDTH-1:0] cap_index;
    logic [31:0]           cap_wdata;
    logic                  resp_valid_q;
    logic                  resp_err_q;

    logic                  req_fault;
    logic [ADDR_WIDTH-1:0] req_index;
    logic                  accept;
    logic                  enter_resp;
    logic                  leave_resp;

    logic                  txn_write;
    logic                  txn_err;
    logic [ADDR_WIDTH-1:0] txn_index;
    logic [31:0]           txn_wdata;

    logic                  mem_wr_en;
    logic                  mem_rd_en;
    logic                  mem_rd_clr;

    assign req_index = req_addr[ADDR_WIDTH+1:2];
    assign req_fault = addr_fault(req_addr, ADDR_WIDTH);

    // With no wait states RESP is entered on the accept edge, so the live request is used.
    assign txn_write = (state_q == IDLE) ? req_write : cap_write;
    assign txn_err   = (state_q == IDLE) ? req_fault : cap_err;
    assign txn_index = (state_q == IDLE) ? req_index : cap_index;
    assign txn_wdata = (state_q == IDLE) ? req_wdata : cap_wdata;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        leave_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d    = IDLE;
                    leave_resp = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_write <= 1'b0;
            cap_err   <= 1'b0;
            cap_index <= '0;
            cap_wdata <= '0;
        end else if (accept) begin
            cap_write <= req_write;
            cap_err   <= req_fault;
            cap_index <= req_index;
            cap_wdata <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= RESP_ERR_NONE;
        end else if (enter_resp) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= txn_err ? RESP_ERR_ADDR : RESP_ERR_NONE;
        end else if (leave_resp) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= RESP_ERR_NONE;
        end
    end

    // Store commits on RESP entry, so it is visible before its response is seen.
    assign mem_wr_en  = enter_resp && txn_write && !txn_err;
    assign mem_rd_en  = enter_resp && !txn_write && !txn_err;
    assign mem_rd_clr = (enter_resp && (txn_write || txn_err)) || leave_resp;

    mem_array #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(32)
    ) u_mem_array (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (mem_wr_en),
        .wr_addr(txn_index),
        .wr_data(txn_wdata),
        .rd_en  (mem_rd_en),
        .rd_clr (mem_rd_clr),
        .rd_addr(txn_index),
        .rd_data(resp_rdata)
    );

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;

endmodule
